// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, functs, FSM states,
// datapath mux selects and ALU function codes.
package mc_pkg;

   localparam logic [3:0] OP_BNE   = 4'd0;
   localparam logic [3:0] OP_BEQ   = 4'd1;
   localparam logic [3:0] OP_BGZ   = 4'd2;
   localparam logic [3:0] OP_BLZ   = 4'd3;
   localparam logic [3:0] OP_ADI   = 4'd4;
   localparam logic [3:0] OP_ORI   = 4'd5;
   localparam logic [3:0] OP_LHI   = 4'd6;
   localparam logic [3:0] OP_LWD   = 4'd7;
   localparam logic [3:0] OP_SWD   = 4'd8;
   localparam logic [3:0] OP_JMP   = 4'd9;
   localparam logic [3:0] OP_JAL   = 4'd10;
   localparam logic [3:0] OP_RTYPE = 4'd15;

   localparam logic [5:0] FN_JPR = 6'd25;
   localparam logic [5:0] FN_JRL = 6'd26;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [1:0] PC_RS  = 2'd3;

   localparam logic [1:0] DST_RT   = 2'd0;
   localparam logic [1:0] DST_RD   = 2'd1;
   localparam logic [1:0] DST_LINK = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MDR = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   localparam logic [1:0] SRCB_RT  = 2'd0;
   localparam logic [1:0] SRCB_ONE = 2'd1;
   localparam logic [1:0] SRCB_IMM = 2'd2;

   // Codes 0..7 coincide with the R-type funct field so EX can pass it through.
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_ORR = 4'd3;
   localparam logic [3:0] ALU_NOT = 4'd4;
   localparam logic [3:0] ALU_TCP = 4'd5;
   localparam logic [3:0] ALU_SHL = 4'd6;
   localparam logic [3:0] ALU_SHR = 4'd7;
   localparam logic [3:0] ALU_LHI = 4'd8;
   localparam logic [3:0] ALU_BNE = 4'd9;
   localparam logic [3:0] ALU_BEQ = 4'd10;
   localparam logic [3:0] ALU_BGZ = 4'd11;
   localparam logic [3:0] ALU_BLZ = 4'd12;

   typedef struct packed {
      logic r_alu;
      logic i_alu;
      logic load;
      logic store;
      logic branch;
      logic jump;
      logic jreg;
      logic link;
      logic wwd;
      logic hlt;
      logic illegal;
   } iclass_t;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational instruction-class decode from opcode and funct.
module mc_inst_decode
   import mc_pkg::*;
(
   input  logic [3:0] i_opcode,
   input  logic [5:0] i_funct,
   output iclass_t    o_cls
);

   always_comb begin
      o_cls = '0;
      case (i_opcode)
         OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: o_cls.branch = 1'b1;
         OP_ADI, OP_ORI, OP_LHI:         o_cls.i_alu  = 1'b1;
         OP_LWD:                         o_cls.load   = 1'b1;
         OP_SWD:                         o_cls.store  = 1'b1;
         OP_JMP:                         o_cls.jump   = 1'b1;
         OP_JAL: begin
            o_cls.jump = 1'b1;
            o_cls.link = 1'b1;
         end
         OP_RTYPE: begin
            if (i_funct <= 6'd7) begin
               o_cls.r_alu = 1'b1;
            end else begin
               case (i_funct)
                  FN_JPR: begin
                     o_cls.jump = 1'b1;
                     o_cls.jreg = 1'b1;
                  end
                  FN_JRL: begin
                     o_cls.jump = 1'b1;
                     o_cls.jreg = 1'b1;
                     o_cls.link = 1'b1;
                  end
                  FN_WWD:  o_cls.wwd     = 1'b1;
                  FN_HLT:  o_cls.hlt     = 1'b1;
                  default: o_cls.illegal = 1'b1;
               endcase
            end
         end
         default: o_cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle TSC control FSM with memory handshake, bus timeout and retire counter.
// Optional MC_ILLEGAL_TRAP_EN: undefined encodings halt and raise sticky `illegal`.
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned LINK_REG    = 2
)(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [WORD_SIZE-1:0] instr,
   input  logic                 bcond,
   input  logic                 mem_ready,
   output logic                 ir_write,
   output logic                 iord,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 pc_write,
   output logic [1:0]           pc_src,
   output logic                 reg_write,
   output logic [1:0]           reg_dst,
   output logic [1:0]           wb_sel,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [3:0]           alu_op,
   output logic                 ext_sign,
   output logic                 out_write,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic                 is_halted,
   output logic                 bus_error
`ifdef MC_ILLEGAL_TRAP_EN
   ,
   output logic                 illegal
`endif
);

   state_t               r_state, w_next;
   logic [15:0]          r_wait;
   logic [WORD_SIZE-1:0] r_num_inst;
   logic                 r_halted, r_bus_err;
   logic                 w_retire, w_timeout, w_req, w_expired;
   logic [3:0]           w_opcode;
   logic [5:0]           w_funct;
   iclass_t              w_cls;
`ifdef MC_ILLEGAL_TRAP_EN
   logic                 r_illegal, w_trap;
`endif

   assign w_opcode  = instr[WORD_SIZE-1 -: 4];
   assign w_funct   = instr[5:0];
   assign w_expired = !mem_ready && (r_wait == 16'(MEM_TIMEOUT - 1));

   mc_inst_decode u_dec (
      .i_opcode (w_opcode),
      .i_funct  (w_funct),
      .o_cls    (w_cls)
   );

   always_comb begin
      w_next    = r_state;
      ir_write  = 1'b0;
      iord      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_INC;
      reg_write = 1'b0;
      reg_dst   = DST_RT;
      wb_sel    = WB_ALU;
      alu_src_a = 1'b0;
      alu_src_b = SRCB_RT;
      alu_op    = ALU_ADD;
      ext_sign  = 1'b0;
      out_write = 1'b0;
      w_retire  = 1'b0;
      w_timeout = 1'b0;
      w_req     = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      w_trap    = 1'b0;
`endif
      // Strobes are forced low for the whole reset cycle, not just after it.
      if (!Reset) begin
         case (r_state)
            S_IF: begin
               iord      = 1'b1;
               mem_read  = 1'b1;
               w_req     = 1'b1;
               alu_src_b = SRCB_ONE;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  w_next   = S_ID;
               end else if (w_expired) begin
                  w_timeout = 1'b1;
                  w_next    = S_HALT;
               end
            end
            S_ID: begin
               if (w_cls.branch) begin
                  alu_src_b = SRCB_IMM;
                  ext_sign  = 1'b1;
                  w_next    = S_EX;
               end else if (w_cls.jump) begin
                  pc_write = 1'b1;
                  pc_src   = w_cls.jreg ? PC_RS : PC_JMP;
                  if (w_cls.link) begin
                     reg_write = 1'b1;
                     reg_dst   = DST_LINK;
                     wb_sel    = WB_PC;
                  end
                  w_retire = 1'b1;
                  w_next   = S_IF;
               end else if (w_cls.hlt) begin
                  w_retire = 1'b1;
                  w_next   = S_HALT;
               end else if (w_cls.illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
                  w_trap = 1'b1;
                  w_next = S_HALT;
`else
                  w_retire = 1'b1;
                  w_next   = S_IF;
`endif
               end else begin
                  w_next = S_EX;
               end
            end
            S_EX: begin
               alu_src_a = 1'b1;
               if (w_cls.r_alu) begin
                  alu_op = w_funct[3:0];
                  w_next = S_WB;
               end else if (w_cls.i_alu) begin
                  alu_src_b = SRCB_IMM;
                  ext_sign  = (w_opcode != OP_ORI);
                  case (w_opcode)
                     OP_ORI:  alu_op = ALU_ORR;
                     OP_LHI:  alu_op = ALU_LHI;
                     default: alu_op = ALU_ADD;
                  endcase
                  w_next = S_WB;
               end else if (w_cls.load || w_cls.store) begin
                  alu_src_b = SRCB_IMM;
                  ext_sign  = 1'b1;
                  w_next    = S_MEM;
               end else if (w_cls.branch) begin
                  case (w_opcode)
                     OP_BNE:  alu_op = ALU_BNE;
                     OP_BEQ:  alu_op = ALU_BEQ;
                     OP_BGZ:  alu_op = ALU_BGZ;
                     default: alu_op = ALU_BLZ;
                  endcase
                  if (bcond) begin
                     pc_write = 1'b1;
                     pc_src   = PC_BR;
                  end
                  w_retire = 1'b1;
                  w_next   = S_IF;
               end else if (w_cls.wwd) begin
                  out_write = 1'b1;
                  w_retire  = 1'b1;
                  w_next    = S_IF;
               end else begin
                  w_next = S_IF;
               end
            end
            S_MEM: begin
               w_req     = 1'b1;
               mem_read  = w_cls.load;
               mem_write = w_cls.store;
               if (mem_ready) begin
                  w_retire = w_cls.store;
                  w_next   = w_cls.store ? S_IF : S_WB;
               end else if (w_expired) begin
                  w_timeout = 1'b1;
                  w_next    = S_HALT;
               end
            end
            S_WB: begin
               reg_write = 1'b1;
               reg_dst   = w_cls.r_alu ? DST_RD : DST_RT;
               wb_sel    = w_cls.load ? WB_MDR : WB_ALU;
               w_retire  = 1'b1;
               w_next    = S_IF;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IF;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= S_IF;
         r_wait     <= '0;
         r_num_inst <= '0;
         r_halted   <= 1'b0;
         r_bus_err  <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
         r_illegal  <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         // Any completed or absent request leaves the counter at zero for the next one.
         if (w_req && !mem_ready) r_wait <= r_wait + 16'd1;
         else                     r_wait <= '0;
         if (w_retire)             r_num_inst <= r_num_inst + WORD_SIZE'(1);
         if (w_timeout)            r_bus_err  <= 1'b1;
         if (w_next == S_HALT)     r_halted   <= 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
         if (w_trap)               r_illegal  <= 1'b1;
`endif
      end
   end

   assign num_inst  = r_num_inst;
   assign is_halted = r_halted;
   assign bus_error = r_bus_err;
`ifdef MC_ILLEGAL_TRAP_EN
   assign illegal   = r_illegal;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed plus randomized bench for mc_ctrl_fsm against a per-instruction-class model.
module tb_mc_ctrl_fsm;

   localparam int unsigned TMO = 4;
`ifdef MC_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam int C_JMP = 0, C_JRG = 1, C_HLT = 2, C_BR = 3, C_WWD = 4;
   localparam int C_RALU = 5, C_IALU = 6, C_LWD = 7, C_SWD = 8, C_ILL = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        Reset = 1'b1, bcond = 1'b0, mem_ready = 1'b0;
   logic [15:0] instr = '0;
   logic        ir_write, iord, mem_read, mem_write, pc_write, reg_write;
   logic        alu_src_a, ext_sign, out_write, is_halted, bus_error;
   logic [1:0]  pc_src, reg_dst, wb_sel, alu_src_b;
   logic [3:0]  alu_op;
   logic [15:0] num_inst;
`ifdef MC_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   logic       rst8 = 1'b1;
   logic [7:0] instr8 = 8'h90;
   logic       irw8, iord8, mrd8, mwr8, pcw8, rw8, asa8, ext8, ow8, hlt8, berr8;
   logic [1:0] pcs8, rd8, wbs8, asb8;
   logic [3:0] aop8;
   logic [7:0] num8;
`ifdef MC_ILLEGAL_TRAP_EN
   logic       ill8;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int m_num   = 0;

   mc_ctrl_fsm #(.WORD_SIZE(16), .MEM_TIMEOUT(TMO), .LINK_REG(2)) dut (
      .Clk(clk), .Reset(Reset), .instr(instr), .bcond(bcond), .mem_ready(mem_ready),
      .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
      .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .ext_sign(ext_sign), .out_write(out_write), .num_inst(num_inst),
      .is_halted(is_halted), .bus_error(bus_error)
`ifdef MC_ILLEGAL_TRAP_EN
      , .illegal(illegal)
`endif
   );

   // Narrow instance so the retire counter wrap is reachable in a few hundred cycles.
   mc_ctrl_fsm #(.WORD_SIZE(8), .MEM_TIMEOUT(TMO), .LINK_REG(2)) dut8 (
      .Clk(clk), .Reset(rst8), .instr(instr8), .bcond(1'b0), .mem_ready(1'b1),
      .ir_write(irw8), .iord(iord8), .mem_read(mrd8), .mem_write(mwr8),
      .pc_write(pcw8), .pc_src(pcs8), .reg_write(rw8), .reg_dst(rd8),
      .wb_sel(wbs8), .alu_src_a(asa8), .alu_src_b(asb8), .alu_op(aop8),
      .ext_sign(ext8), .out_write(ow8), .num_inst(num8),
      .is_halted(hlt8), .bus_error(berr8)
`ifdef MC_ILLEGAL_TRAP_EN
      , .illegal(ill8)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int classify(input logic [15:0] iw, output bit link);
      int op = int'(iw[15:12]);
      int fn = int'(iw[5:0]);
      link = 1'b0;
      if (op <= 3)      return C_BR;
      if (op <= 6)      return C_IALU;
      if (op == 7)      return C_LWD;
      if (op == 8)      return C_SWD;
      if (op == 9)      return C_JMP;
      if (op == 10) begin link = 1'b1; return C_JMP; end
      if (op != 15)     return C_ILL;
      if (fn < 8)       return C_RALU;
      if (fn == 25)     return C_JRG;
      if (fn == 26) begin link = 1'b1; return C_JRG; end
      if (fn == 28)     return C_WWD;
      if (fn == 29)     return C_HLT;
      return C_ILL;
   endfunction

   // Starts just after a falling edge with the DUT in fetch; returns at the falling
   // edge where the next fetch begins or the halt becomes visible.
   task automatic exec(input string tag, input logic [15:0] iw, input bit bc,
                       input int wif, input int wmem, output bit halted);
      int k = 0, req_idx = 0, req_cyc = 0;
      int n_pcw = 0, n_irw = 0, n_rd = 0, n_wr = 0, n_rw = 0, n_out = 0, both = 0;
      logic [1:0] x_src = '0, rw_dst = '0, rw_sel = '0, ex_b = '0;
      logic [3:0] ex_op = '0;
      logic ex_ext = 1'b0;
      logic [15:0] n0 = num_inst;
      bit left_if = 0, done = 0, ir_seen, link, is_mem, tmo_if, tmo_mem, trap_ill, retire, jump;
      int cls, base, lat, e_rd, e_wr, e_pcw, e_rw;
      bcond = bc;
      while (!done) begin
         mem_ready = (mem_read || mem_write) && (req_cyc == (req_idx == 0 ? wif : wmem));
         #1;
         if (mem_read && mem_write) both++;
         if (mem_read) n_rd++;
         if (mem_write) n_wr++;
         if (ir_write) n_irw++;
         if (pc_write) begin n_pcw++; if (!ir_write) x_src = pc_src; end
         if (reg_write) begin n_rw++; rw_dst = reg_dst; rw_sel = wb_sel; end
         if (out_write) n_out++;
         if (k == wif + 2) begin ex_op = alu_op; ex_b = alu_src_b; ex_ext = ext_sign; end
         if (!(iord && mem_read)) left_if = 1;
         if (mem_read || mem_write) begin
            if (mem_ready) begin req_idx++; req_cyc = 0; end
            else req_cyc++;
         end
         ir_seen = ir_write;
         @(negedge clk);
         k++;
         if (ir_seen) instr = iw;
         if (is_halted || (left_if && iord && mem_read) || k > 60) done = 1;
      end

      cls      = classify(iw, link);
      jump     = (cls == C_JMP || cls == C_JRG);
      is_mem   = (cls == C_LWD || cls == C_SWD);
      tmo_if   = (wif >= int'(TMO));
      tmo_mem  = !tmo_if && is_mem && (wmem >= int'(TMO));
      trap_ill = TRAP && cls == C_ILL;
      case (cls)
         C_BR, C_WWD:           base = 3;
         C_RALU, C_IALU, C_SWD: base = 4;
         C_LWD:                 base = 5;
         default:               base = 2;
      endcase
      if (tmo_if)       lat = int'(TMO);
      else if (tmo_mem) lat = wif + 3 + int'(TMO);
      else              lat = base + wif + (is_mem ? wmem : 0);
      halted = tmo_if || tmo_mem || cls == C_HLT || trap_ill;
      retire = !(tmo_if || tmo_mem || trap_ill);
      e_rd  = tmo_if ? int'(TMO) : wif + 1 + ((cls == C_LWD) ? (tmo_mem ? int'(TMO) : wmem + 1) : 0);
      e_wr  = (!tmo_if && cls == C_SWD) ? (tmo_mem ? int'(TMO) : wmem + 1) : 0;
      e_pcw = tmo_if ? 0 : 1 + (jump ? 1 : 0) + ((cls == C_BR && bc) ? 1 : 0);
      e_rw  = (tmo_if || tmo_mem) ? 0 :
              ((jump && link) || cls == C_RALU || cls == C_IALU || cls == C_LWD) ? 1 : 0;

      check({tag, "/latency"}, k, lat);
      check({tag, "/mem_read_cycles"}, n_rd, e_rd);
      check({tag, "/mem_write_cycles"}, n_wr, e_wr);
      check({tag, "/rd_wr_overlap"}, both, 0);
      check({tag, "/ir_write"}, n_irw, tmo_if ? 0 : 1);
      check({tag, "/pc_write"}, n_pcw, e_pcw);
      if (!tmo_if && jump)                check({tag, "/pc_src"}, x_src, cls == C_JRG ? 3 : 2);
      if (!tmo_if && cls == C_BR && bc)   check({tag, "/pc_src"}, x_src, 1);
      check({tag, "/reg_write"}, n_rw, e_rw);
      if (e_rw == 1) begin
         check({tag, "/reg_dst"}, rw_dst, link ? 2 : (cls == C_RALU ? 1 : 0));
         check({tag, "/wb_sel"}, rw_sel, link ? 2 : (cls == C_LWD ? 1 : 0));
      end
      check({tag, "/out_write"}, n_out, (!tmo_if && cls == C_WWD) ? 1 : 0);
      if (!tmo_if && (cls == C_RALU || cls == C_IALU || is_mem)) begin
         check({tag, "/alu_src_b"}, ex_b, cls == C_RALU ? 0 : 2);
         if (cls == C_RALU) check({tag, "/alu_op"}, ex_op, iw[3:0]);
         else               check({tag, "/ext_sign"}, ex_ext, iw[15:12] == 4'd5 ? 0 : 1);
      end
      check({tag, "/num_delta"}, 16'(num_inst - n0), retire ? 1 : 0);
      if (retire) m_num++;
      check({tag, "/num_inst"}, num_inst, 16'(m_num));
      check({tag, "/is_halted"}, is_halted, halted);
      check({tag, "/bus_error"}, bus_error, tmo_if || tmo_mem);
`ifdef MC_ILLEGAL_TRAP_EN
      check({tag, "/illegal"}, illegal, trap_ill);
`endif
   endtask

   task automatic idle_check(input string tag);
      int act = 0;
      logic [15:0] n0 = num_inst;
      mem_ready = 1'b1;
      repeat (20) begin
         #1;
         if (ir_write | mem_read | mem_write | pc_write | reg_write | out_write) act++;
         @(negedge clk);
      end
      check({tag, "/halt_strobes"}, act, 0);
      check({tag, "/halt_num"}, num_inst, n0);
      check({tag, "/halt_sticky"}, is_halted, 1);
   endtask

   task automatic do_reset(input string tag);
      Reset = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      check({tag, "/rst_strobes"},
            {26'd0, ir_write, mem_read, mem_write, pc_write, reg_write, out_write}, 0);
      Reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      check({tag, "/rst_num"}, num_inst, 0);
      check({tag, "/rst_flags"}, {30'd0, is_halted, bus_error}, 0);
      check({tag, "/rst_fetch"}, {30'd0, iord, mem_read}, 3);
      m_num = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit h;
      logic [15:0] iw;
      int r, wif, wmem;

      repeat (2) @(negedge clk);
      rst8 = 1'b0;
      repeat (510) @(negedge clk);
      check("wrap/at_max", num8, 8'hFF);
      repeat (2) @(negedge clk);
      check("wrap/to_zero", num8, 8'h00);

      do_reset("init");
      exec("adi", 16'h4105, 1'b0, 0, 0, h);
      exec("lwd_wait3", 16'h7105, 1'b0, 0, 3, h);
      exec("beq_taken", 16'h1203, 1'b1, 0, 0, h);
      exec("beq_not", 16'h1203, 1'b0, 0, 0, h);
      exec("jal", 16'hA123, 1'b0, 0, 0, h);
      exec("swd_wait1", 16'h8102, 1'b0, 1, 1, h);
      exec("if_timeout", 16'h4105, 1'b0, 100, 0, h);
      idle_check("if_timeout");

      do_reset("midwait");
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      #1;
      check("midwait/restart_fetch", {30'd0, iord, mem_read}, 3);
      check("midwait/no_bus_error", bus_error, 0);
      exec("midwait_adi", 16'h4105, 1'b0, int'(TMO) - 1, 0, h);

      exec("hlt", 16'hF01D, 1'b0, 0, 0, h);
      idle_check("hlt");

      do_reset("rand");
      for (int i = 0; i < 80; i++) begin
         iw = 16'($urandom);
         iw[15:12] = 4'($urandom_range(0, 15));
         if (iw[15:12] == 4'hF) begin
            r = $urandom_range(0, 9);
            if (r < 5)       iw[5:0] = 6'(r);
            else if (r == 5) iw[5:0] = 6'd25;
            else if (r == 6) iw[5:0] = 6'd26;
            else if (r == 7) iw[5:0] = 6'd28;
            else if (r == 8) iw[5:0] = 6'd29;
         end
         wif  = ($urandom_range(0, 24) == 0) ? int'(TMO) : $urandom_range(0, 2);
         wmem = ($urandom_range(0, 9) == 0) ? int'(TMO) : $urandom_range(0, 2);
         exec("rand", iw, 1'($urandom), wif, wmem, h);
         if (h) begin
            idle_check("rand");
            do_reset("rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
